seq_divider: RTL and testbench

//  Multi-cycle restoring divider. Computes quotient and remainder of two N-bit operands, one quotient bit per clock.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 33 +++
 rtl/seq_divider.sv | 158 +++++++++++++++
 tb/tb_seq_divider.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Signed two's-complement operation is enabled by defining SIGNED_DIV_EN.
package div_pkg;

    localparam int DEFAULT_N     = 4;
    localparam int DEFAULT_CNT_W = 5;

    // Quotient is filled with this bit when the divisor is zero
    localparam logic DIV0_FILL_BIT = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, then
// subtract the divisor if it fits, producing one quotient bit.
module div_step
    import div_pkg::*;
#(
    parameter int N = DEFAULT_N
)(
    input  logic [N:0]   i_rem,
    input  logic         i_bit,
    input  logic [N-1:0] i_divisor,
    output logic [N:0]   o_rem,
    output logic         o_qbit
);

    logic [N:0] w_shifted;
    logic [N:0] w_diff;
    logic       w_unusedRemTop;

    // The restored remainder is always below the divisor, so its top bit is never needed
    assign w_unusedRemTop = i_rem[N];
    assign w_shifted      = {i_rem[N-1:0], i_bit};
    assign w_diff         = w_shifted - {1'b0, i_divisor};

    always_comb begin
        o_qbit = 1'b0;
        o_rem  = w_shifted;
        if (w_shifted >= {1'b0, i_divisor}) begin
            o_qbit = 1'b1;
            o_rem  = w_diff;
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN for two's-complement operands (sign fix-up on result load).
module seq_divider
    import div_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int CNT_W = DEFAULT_CNT_W
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_zero
);

    state_t           r_state;
    state_t           w_nextState;
    logic [N:0]       r_rem;
    logic [N-1:0]     r_q;
    logic [N-1:0]     r_divisor;
    logic [N-1:0]     r_dividend;
    logic [CNT_W-1:0] r_count;
    logic             r_zero;
    logic             r_done;
    logic [N-1:0]     r_quotient;
    logic [N-1:0]     r_remainder;
    logic             r_divZero;

    logic [N:0]       w_stepRem;
    logic             w_stepBit;
    logic             w_lastStep;
    logic [N-1:0]     w_opDividend;
    logic [N-1:0]     w_opDivisor;
    logic [N-1:0]     w_resQuot;
    logic [N-1:0]     w_resRem;

`ifdef SIGNED_DIV_EN
    logic r_negQuot;
    logic r_negRem;

    // The unsigned core sees magnitudes; the most-negative value maps to 2^(N-1), which still fits
    assign w_opDividend = dividend[N-1] ? -dividend : dividend;
    assign w_opDivisor  = divisor[N-1]  ? -divisor  : divisor;
    assign w_resQuot    = r_negQuot ? -r_q : r_q;
    assign w_resRem     = r_negRem  ? -r_rem[N-1:0] : r_rem[N-1:0];
`else
    assign w_opDividend = dividend;
    assign w_opDivisor  = divisor;
    assign w_resQuot    = r_q;
    assign w_resRem     = r_rem[N-1:0];
`endif

    assign w_lastStep = (r_count == CNT_W'(N - 1));
    assign busy       = (r_state != S_IDLE);
    assign done       = r_done;
    assign quotient   = r_quotient;
    assign remainder  = r_remainder;
    assign div_zero   = r_divZero;

    div_step #(.N(N)) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_q[N-1]),
        .i_divisor (r_divisor),
        .o_rem     (w_stepRem),
        .o_qbit    (w_stepBit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // A zero divisor skips the iterations entirely
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_lastStep) begin
                    w_nextState = S_DONE;
                end
            end
            S_DONE:  w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rem       <= '0;
            r_q         <= '0;
            r_divisor   <= '0;
            r_dividend  <= '0;
            r_count     <= '0;
            r_zero      <= 1'b0;
            r_done      <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_divZero   <= 1'b0;
`ifdef SIGNED_DIV_EN
            r_negQuot   <= 1'b0;
            r_negRem    <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rem      <= '0;
                        r_q        <= w_opDividend;
                        r_divisor  <= w_opDivisor;
                        r_dividend <= dividend;
                        r_zero     <= (divisor == '0);
                        r_count    <= '0;
                        if (divisor != '0) begin
                            r_divZero <= 1'b0;
                        end
`ifdef SIGNED_DIV_EN
                        r_negQuot  <= dividend[N-1] ^ divisor[N-1];
                        r_negRem   <= dividend[N-1];
`endif
                    end
                end
                S_RUN: begin
                    r_rem   <= w_stepRem;
                    r_q     <= {r_q[N-2:0], w_stepBit};
                    r_count <= r_count + CNT_W'(1);
                end
                S_DONE: begin
                    r_done <= 1'b1;
                    if (r_zero) begin
                        r_quotient  <= {N{DIV0_FILL_BIT}};
                        r_remainder <= r_dividend;
                        r_divZero   <= 1'b1;
                    end else begin
                        r_quotient  <= w_resQuot;
                        r_remainder <= w_resRem;
                        r_divZero   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases, exhaustive sweep and
// random cycle-level traffic against a queue-based arithmetic model.
module tb_seq_divider;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_zero;

    int checkCount = 0;
    int passCount  = 0;
    int cyc        = 0;

    typedef struct {
        int           due;
        logic [N-1:0] q;
        logic [N-1:0] r;
        logic         dz;
    } exp_t;

    exp_t expQ[$];

    seq_divider #(.N(N), .CNT_W(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int got, input int want);
        checkCount++;
        if (got == want) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Expected result and latency from plain arithmetic on the accepted operands
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int acceptCyc);
        exp_t e;
        int   qa;
        int   ra;
`ifdef SIGNED_DIV_EN
        int   sa;
        int   sb;
        sa = int'(a);
        sb = int'(b);
        if (a[N-1]) sa = sa - (1 << N);
        if (b[N-1]) sb = sb - (1 << N);
`endif
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dz  = 1'b1;
            e.due = acceptCyc + 2;
        end else begin
`ifdef SIGNED_DIV_EN
            if (sa == -(1 << (N - 1)) && sb == -1) begin
                qa = sa;
                ra = 0;
            end else begin
                qa = sa / sb;
                ra = sa % sb;
            end
`else
            qa = int'(a) / int'(b);
            ra = int'(a) % int'(b);
`endif
            e.q   = N'(qa);
            e.r   = N'(ra);
            e.dz  = 1'b0;
            e.due = acceptCyc + N + 2;
        end
        return e;
    endfunction

    // Single compare process: track accepted starts and check every cycle
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            expQ.delete();
        end else begin
            if (expQ.size() > 0 && expQ[0].due == cyc) begin
                checkOutput("done", int'(done), 1);
                checkOutput("quotient", int'(quotient), int'(expQ[0].q));
                checkOutput("remainder", int'(remainder), int'(expQ[0].r));
                checkOutput("div_zero", int'(div_zero), int'(expQ[0].dz));
                void'(expQ.pop_front());
            end else begin
                checkOutput("done_idle", int'(done), 0);
            end
            if (start && !busy) begin
                expQ.push_back(model(dividend, divisor, cyc));
            end
        end
    end

    task automatic waitIdle();
        for (int i = 0; i < 20; i++) begin
            if (!busy) return;
            @(posedge clk); #1;
        end
        checkOutput("idle_timeout", int'(busy), 0);
    endtask

    task automatic waitDrain();
        for (int i = 0; i < 3 * N + 12; i++) begin
            if (expQ.size() == 0) return;
            @(posedge clk); #1;
        end
        checkOutput("drain_timeout", expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        waitIdle();
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk); #1;
        start    = 1'b0;
        dividend = N'($urandom_range(0, (1 << N) - 1));
        divisor  = N'($urandom_range(0, (1 << N) - 1));
        waitDrain();
    endtask

    task automatic expectResult(input string name, input int q, input int r, input int dz);
        checkOutput({name, "_q"}, int'(quotient), q);
        checkOutput({name, "_r"}, int'(remainder), r);
        checkOutput({name, "_dz"}, int'(div_zero), dz);
    endtask

    task automatic expectAllZero(input string name);
        checkOutput({name, "_busy"}, int'(busy), 0);
        checkOutput({name, "_done"}, int'(done), 0);
        expectResult(name, 0, 0, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        expectAllZero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifndef SIGNED_DIV_EN
        applyStimulus(4'd13, 4'd4);
        expectResult("13div4", 3, 1, 0);
        applyStimulus(4'd15, 4'd0);
        expectResult("15div0", 15, 15, 1);
        applyStimulus(4'd9, 4'd3);
        expectResult("9div3", 3, 0, 0);
        applyStimulus(4'd0, 4'd7);
        expectResult("0div7", 0, 0, 0);
        applyStimulus(4'd15, 4'd1);
        expectResult("15div1", 15, 0, 0);
        applyStimulus(4'd5, 4'd9);
        expectResult("5div9", 0, 5, 0);
        applyStimulus(4'd15, 4'd15);
        expectResult("15div15", 1, 0, 0);
`else
        applyStimulus(4'b1001, 4'd2);
        expectResult("m7div2", 13, 15, 0);
        applyStimulus(4'd7, 4'b1110);
        expectResult("7divm2", 13, 1, 0);
        applyStimulus(4'b1000, 4'b1111);
        expectResult("m8divm1", 8, 0, 0);
`endif

        // Second start while busy must be ignored
        waitIdle();
        start    = 1'b1;
        dividend = 4'd14;
        divisor  = 4'd3;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start    = 1'b1;
        dividend = 4'd1;
        divisor  = 4'd1;
        checkOutput("busy_ignore", int'(busy), 1);
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_hold", int'(busy), 1);
        waitDrain();
`ifndef SIGNED_DIV_EN
        expectResult("14div3", 4, 2, 0);
`endif

        // Reset in the middle of an operation aborts it
        waitIdle();
        start    = 1'b1;
        dividend = 4'd11;
        divisor  = 4'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        expectAllZero("midreset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(4'd12, 4'd5);
        expectResult("12div5", 2, 2, 0);

        for (int a = 0; a < (1 << N); a++) begin
            for (int b = 0; b < (1 << N); b++) begin
                applyStimulus(N'(a), N'(b));
            end
        end

        // Random traffic: start pulses at arbitrary times, operands change every cycle
        for (int i = 0; i < 2000; i++) begin
            start    = ($urandom_range(0, 2) == 0);
            dividend = N'($urandom_range(0, (1 << N) - 1));
            divisor  = ($urandom_range(0, 9) == 0) ? '0 : N'($urandom_range(0, (1 << N) - 1));
            @(posedge clk); #1;
        end
        start = 1'b0;
        waitDrain();
        repeat (3) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
